// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   XLEN        : program counter width in bits
//   INSTR_W     : instruction width in bits
//   NOP_INSTR   : instruction presented whenever no valid fetch is on the output
//   fetch_entry_t : one fetched instruction paired with its byte PC
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry synchronous FIFO of fetch entries that absorbs decode backpressure.
//   clk_i       : clock, all state on rising edge
//   rst_i       : synchronous active-high reset, empties the buffer
//   push_i      : write push_data_i at the tail this edge
//   push_data_i : entry to store
//   pop_i       : drop the head entry this edge
//   flush_i     : discard all entries this edge (wins over push/pop)
//   head_o      : oldest stored entry (meaningful only when occ_o != 0)
//   occ_o       : number of stored entries, 0..2
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   occ_o
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   occ_q, occ_d;
  logic         wr_ptr;
  logic         do_pop, do_push;

  assign do_pop  = pop_i && (occ_q != 2'd0);
  // A full buffer still accepts a push when the head leaves at the same edge.
  assign do_push = push_i && ((occ_q != 2'd2) || do_pop);
  // Tail slot is the head slot offset by the current occupancy (mod 2).
  assign wr_ptr  = rd_ptr_q ^ occ_q[0];

  always_comb begin
    rd_ptr_d = rd_ptr_q ^ do_pop;
    occ_d    = occ_q + {1'b0, do_push} - {1'b0, do_pop};
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      occ_d    = 2'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage carries no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr] <= push_data_i;
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction RAM, captures
// the returned word one cycle later and hands {instr, pc} to decode over a
// valid/ready handshake, with a 2-entry skid buffer and redirect support.
//   Clk        : clock, all state on rising edge
//   Rst        : synchronous active-high reset (highest priority)
//   IramAddr   : RAM word address, fetch_pc[AW+1:2]
//   IramData   : RAM read data, valid the cycle after the address
//   Redirect   : restart fetch at RedirectPc, flushing everything in flight
//   RedirectPc : redirect byte target, bits [1:0] ignored
//   OutValid   : OutInstr/OutPc hold a valid fetched instruction
//   OutReady   : decode accepts the current output
//   OutInstr   : fetched instruction, NOP when OutValid=0
//   OutPc      : byte PC of OutInstr, 0 when OutValid=0
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    XLEN     = fetch_pkg::XLEN,
  parameter int                    K        = 512,
  parameter logic [XLEN-1:0]       RESET_PC = '0,
  localparam int                   AW       = $clog2(K)
) (
  input  logic               Clk,
  input  logic               Rst,
  output logic [AW-1:0]      IramAddr,
  input  logic [INSTR_W-1:0] IramData,
  input  logic               Redirect,
  input  logic [XLEN-1:0]    RedirectPc,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [INSTR_W-1:0] OutInstr,
  output logic [XLEN-1:0]    OutPc
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            req_valid_q, req_valid_d;

  logic [1:0]      occ;
  fetch_entry_t    head;
  fetch_entry_t    ret_entry;
  logic            pop, push, issue;
  logic [2:0]      pending;

  logic            unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^RedirectPc[1:0];

  assign IramAddr = fetch_pc_q[AW+1:2];
  assign pop      = OutValid && OutReady;

  // Entries that will still be held after this edge; a new read may only be
  // launched if its data is guaranteed a slot when it returns.
  assign pending  = {1'b0, occ} + {2'b0, req_valid_q} - {2'b0, pop};
  assign issue    = !Redirect && (pending < 3'd2);

  // Returned data goes to the buffer unless bypass hands it straight to decode.
  assign push      = req_valid_q && !((occ == 2'd0) && pop);
  assign ret_entry = '{instr: IramData, pc: req_pc_q};

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = 1'b0;
    if (Redirect) begin
      fetch_pc_d = {RedirectPc[XLEN-1:2], 2'b00};
    end else if (issue) begin
      req_valid_d = 1'b1;
      req_pc_d    = fetch_pc_q;
      fetch_pc_d  = fetch_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      fetch_pc_q  <= RESET_PC;
      req_valid_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_valid_q <= req_valid_d;
    end
  end

  always_ff @(posedge Clk) begin
    req_pc_q <= req_pc_d;
  end

  fetch_skid_buffer u_skid (
    .clk_i       (Clk),
    .rst_i       (Rst),
    .push_i      (push),
    .push_data_i (ret_entry),
    .pop_i       (pop),
    .flush_i     (Redirect),
    .head_o      (head),
    .occ_o       (occ)
  );

  // Buffered entries are older than the in-flight read, so they go first.
  always_comb begin
    OutValid = 1'b0;
    OutInstr = NOP_INSTR;
    OutPc    = '0;
    if (occ != 2'd0) begin
      OutValid = 1'b1;
      OutInstr = head.instr;
      OutPc    = head.pc;
    end else if (req_valid_q) begin
      OutValid = 1'b1;
      OutInstr = IramData;
      OutPc    = req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int XLEN = 32;
  localparam int K    = 512;
  localparam int AW   = 9;

  logic            Clk = 1'b0;
  logic            Rst = 1'b1;
  logic [AW-1:0]   IramAddr;
  logic [31:0]     IramData;
  logic            Redirect = 1'b0;
  logic [XLEN-1:0] RedirectPc = '0;
  logic            OutValid;
  logic            OutReady = 1'b0;
  logic [31:0]     OutInstr;
  logic [XLEN-1:0] OutPc;

  always #5 Clk = ~Clk;

  fetch_unit #(.XLEN(XLEN), .K(K), .RESET_PC(32'h0)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .IramAddr   (IramAddr),
    .IramData   (IramData),
    .Redirect   (Redirect),
    .RedirectPc (RedirectPc),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutInstr   (OutInstr),
    .OutPc      (OutPc)
  );

  // Synchronous-read instruction RAM, mem[i] = 0x1000_0000 + i
  logic [31:0] ram [K];
  initial for (int i = 0; i < K; i++) ram[i] = 32'h1000_0000 + i;
  always @(posedge Clk) IramData <= ram[IramAddr];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the output is the architectural stream exp_pc, exp_pc+4, ...
  // restarted by every reset/redirect; nothing appears the cycle after a flush,
  // the target appears the cycle after that and the stream never gaps again.
  logic [XLEN-1:0] exp_pc     = '0;
  logic [AW-1:0]   flush_word = '0;
  int              since      = 0;
  logic            model_on   = 1'b0;

  function automatic logic [31:0] ref_instr(input logic [XLEN-1:0] pc);
    int unsigned w;
    w = (pc / 4) % K;
    return 32'h1000_0000 + w;
  endfunction

  task automatic cycle(input logic rst, input logic rdy, input logic redir,
                       input logic [XLEN-1:0] tgt);
    logic exp_valid;
    Rst = rst; OutReady = rdy; Redirect = redir; RedirectPc = tgt;
    exp_valid = model_on && (since >= 2);
    if (model_on) begin
      if (since == 1) begin
        chk("flush_valid", 64'(OutValid), 64'(1'b0));
        chk("flush_addr", 64'(IramAddr), 64'(flush_word));
      end else if (since >= 2) begin
        chk("stream_valid", 64'(OutValid), 64'(1'b1));
      end
      if (exp_valid) begin
        chk("pc", 64'(OutPc), 64'(exp_pc));
        chk("instr", 64'(OutInstr), 64'(ref_instr(exp_pc)));
      end else begin
        chk("idle_instr", 64'(OutInstr), 64'(32'h0000_0013));
        chk("idle_pc", 64'(OutPc), 64'(0));
      end
    end
    if (rst) begin
      exp_pc = '0; flush_word = '0; since = 0; model_on = 1'b1;
    end else if (model_on) begin
      if (exp_valid && rdy) exp_pc = exp_pc + 4;
      if (redir) begin
        exp_pc = {tgt[XLEN-1:2], 2'b00};
        flush_word = tgt[AW+1:2];
        since = 0;
      end
    end
    if (model_on) since++;
    @(posedge Clk); #1;
  endtask

  logic [AW-1:0] a0;
  int n;

  initial begin
    #1;
    // Reset and streaming from RESET_PC with decode always ready
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    chk("rst_valid", 64'(OutValid), 64'(1'b0));
    chk("rst_addr", 64'(IramAddr), 64'(0));
    cycle(0, 1, 0, 0);
    chk("first_valid", 64'(OutValid), 64'(1'b1));
    chk("first_pc", 64'(OutPc), 64'(0));
    for (int i = 0; i < 3; i++) begin
      chk("stream_addr", 64'(IramAddr), 64'((OutPc + 4) / 4));
      cycle(0, 1, 0, 0);
    end

    // Stall at OutPc=0x10 for 4 cycles
    n = 0;
    while (OutPc !== 32'h10 && n < 20) begin cycle(0, 1, 0, 0); n++; end
    chk("reach_0x10", 64'(OutPc), 64'(32'h10));
    for (int i = 0; i < 4; i++) begin
      if (i >= 1) chk("stall_addr", 64'(IramAddr), 64'(6));
      chk("stall_pc", 64'(OutPc), 64'(32'h10));
      chk("stall_instr", 64'(OutInstr), 64'(32'h1000_0004));
      cycle(0, 0, 0, 0);
    end
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0);

    // Redirect while streaming
    cycle(0, 1, 1, 32'h100);
    cycle(0, 1, 0, 0);
    chk("redir_pc", 64'(OutPc), 64'(32'h100));
    chk("redir_instr", 64'(OutInstr), 64'(32'h1000_0040));
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);

    // Redirect while stalled with a full buffer, misaligned target
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h43);
    cycle(0, 1, 0, 0);
    chk("stall_redir_pc", 64'(OutPc), 64'(32'h40));
    chk("stall_redir_instr", 64'(OutInstr), 64'(32'h1000_0010));

    // RAM address wrap at the top of the instruction RAM
    cycle(0, 1, 1, 32'h7FC);
    a0 = IramAddr;
    chk("wrap_addr_hi", 64'(a0), 64'(511));
    cycle(0, 1, 0, 0);
    chk("wrap_addr_lo", 64'(IramAddr), 64'(0));
    chk("wrap_pc0", 64'(OutPc), 64'(32'h7FC));
    cycle(0, 1, 0, 0);
    chk("wrap_pc1", 64'(OutPc), 64'(32'h800));
    chk("wrap_instr1", 64'(OutInstr), 64'(32'h1000_0000));
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);

    // Reset together with redirect while one entry is buffered
    cycle(0, 0, 0, 0);
    cycle(1, 1, 1, 32'h300);
    chk("rst_redir_valid", 64'(OutValid), 64'(1'b0));
    chk("rst_redir_addr", 64'(IramAddr), 64'(0));
    cycle(0, 1, 0, 0);
    chk("rst_redir_pc", 64'(OutPc), 64'(0));

    // Randomized traffic, including PC wrap at 2^XLEN
    for (int i = 0; i < 3000; i++) begin
      logic r, rd, rv;
      logic [XLEN-1:0] t;
      r  = ($urandom_range(0, 199) == 0);
      rd = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 19) == 0);
      t  = $urandom;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      cycle(r, rd, rv, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
